// File: rtl/lcd_init_ctrl.sv
// Boot sequencer for an HD44780-style 8-bit LCD: replays a 4-word command ROM
// with E-strobe and busy-wait timing, then accepts user words over valid/ready.
module lcd_init_ctrl #(
    parameter int POWERUP_WAIT   = 750000,
    parameter int SETUP_CYCLES   = 4,
    parameter int E_PULSE_CYCLES = 25,
    parameter int CMD_WAIT       = 2000,
    parameter int CLEAR_WAIT     = 82000
) (
    input  logic       clk,
    input  logic       rst,
    output logic [2:0] rom_addr,
    input  logic [8:0] rom_q,
    input  logic       rom_rdy,
    input  logic       char_valid,
    input  logic [8:0] char_data,
    output logic       char_ready,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic       init_done
);

    localparam int MAX_A    = (POWERUP_WAIT > SETUP_CYCLES) ? POWERUP_WAIT : SETUP_CYCLES;
    localparam int MAX_B    = (E_PULSE_CYCLES > CMD_WAIT) ? E_PULSE_CYCLES : CMD_WAIT;
    localparam int MAX_C    = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_WAIT = (MAX_C > CLEAR_WAIT) ? MAX_C : CLEAR_WAIT;
    localparam int CW       = $clog2(MAX_WAIT) + 1;

    localparam logic [CW-1:0] PW_LAST  = CW'(POWERUP_WAIT - 1);
    localparam logic [CW-1:0] SU_LAST  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] EP_LAST  = CW'(E_PULSE_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [2:0]    ROM_END  = 3'd4;

    typedef enum logic [2:0] {
        S_POWERUP,
        S_FETCH,
        S_SETUP,
        S_PULSE,
        S_WAIT,
        S_IDLE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    rom_addr_q, rom_addr_d;
    logic [7:0]    lcd_data_q, lcd_data_d;
    logic          lcd_rs_q, lcd_rs_d;
    logic          lcd_e_q, lcd_e_d;
    logic          char_ready_q, char_ready_d;
    logic          init_done_q, init_done_d;
    logic          is_clear;
    logic [CW-1:0] wait_last;

    // Clear (0x01) and home (0x02/0x03) need the long busy wait.
    assign is_clear  = !lcd_rs_q && (lcd_data_q[7:1] == 7'd0);
    assign wait_last = is_clear ? CLR_LAST : CMD_LAST;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_POWERUP;
            cnt_q        <= '0;
            rom_addr_q   <= '0;
            lcd_data_q   <= '0;
            lcd_rs_q     <= 1'b0;
            lcd_e_q      <= 1'b0;
            char_ready_q <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rom_addr_q   <= rom_addr_d;
            lcd_data_q   <= lcd_data_d;
            lcd_rs_q     <= lcd_rs_d;
            lcd_e_q      <= lcd_e_d;
            char_ready_q <= char_ready_d;
            init_done_q  <= init_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rom_addr_d  = rom_addr_q;
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        init_done_d = init_done_q;

        case (state_q)
            S_POWERUP: begin
                if (cnt_q == PW_LAST) begin
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_FETCH: begin
                cnt_d = '0;
                if (rom_rdy) begin
                    state_d = S_IDLE;
                end else begin
                    lcd_rs_d   = rom_q[8];
                    lcd_data_d = rom_q[7:0];
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_q == SU_LAST) begin
                    cnt_d   = '0;
                    state_d = S_PULSE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_PULSE: begin
                if (cnt_q == EP_LAST) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_WAIT: begin
                if (cnt_q == wait_last) begin
                    cnt_d = '0;
                    // init_done distinguishes a user write from a boot command.
                    if (init_done_q) begin
                        state_d = S_IDLE;
                    end else begin
                        if (rom_addr_q != ROM_END) begin
                            rom_addr_d = rom_addr_q + 3'd1;
                        end
                        state_d = S_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_IDLE: begin
                cnt_d = '0;
                if (char_valid && char_ready_q) begin
                    lcd_rs_d   = char_data[8];
                    lcd_data_d = char_data[7:0];
                    state_d    = S_SETUP;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_POWERUP;
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        lcd_e_d      = (state_d == S_PULSE);
        char_ready_d = (state_d == S_IDLE);
        if (state_d == S_IDLE) begin
            init_done_d = 1'b1;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign lcd_data   = lcd_data_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_e      = lcd_e_q;
    assign char_ready = char_ready_q;
    assign init_done  = init_done_q;

endmodule

// File: tb/tb_lcd_init_ctrl.sv
// Directed bench for lcd_init_ctrl: boot replay, E timing, user writes,
// handshake stalls and reset during an E pulse.
module tb_lcd_init_ctrl;

    localparam int POWERUP_WAIT   = 10;
    localparam int SETUP_CYCLES   = 2;
    localparam int E_PULSE_CYCLES = 3;
    localparam int CMD_WAIT       = 5;
    localparam int CLEAR_WAIT     = 20;
    localparam int GAP_CMD        = CMD_WAIT + 1 + SETUP_CYCLES;
    localparam int GAP_CLR        = CLEAR_WAIT + 1 + SETUP_CYCLES;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] rom_addr;
    logic [8:0] rom_q;
    logic       rom_rdy;
    logic       force_rdy;
    logic       char_valid;
    logic [8:0] char_data;
    logic       char_ready;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_e;
    logic       init_done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    lcd_init_ctrl #(
        .POWERUP_WAIT  (POWERUP_WAIT),
        .SETUP_CYCLES  (SETUP_CYCLES),
        .E_PULSE_CYCLES(E_PULSE_CYCLES),
        .CMD_WAIT      (CMD_WAIT),
        .CLEAR_WAIT    (CLEAR_WAIT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .rom_rdy   (rom_rdy),
        .char_valid(char_valid),
        .char_data (char_data),
        .char_ready(char_ready),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_e     (lcd_e),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    // Standard boot ROM: function set, entry mode, clear, display on.
    always_comb begin
        case (rom_addr)
            3'd0:    rom_q = 9'h03C;
            3'd1:    rom_q = 9'h006;
            3'd2:    rom_q = 9'h001;
            3'd3:    rom_q = 9'h00F;
            default: rom_q = 9'h000;
        endcase
    end
    assign rom_rdy = (rom_addr == 3'd4) || force_rdy;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // E-pulse monitor: rise/fall cycles, latched word, and RS/data stability.
    int         rise_q[$];
    int         fall_q[$];
    logic [8:0] word_q[$];
    int         stable_bad = 0;
    logic       e_prev = 1'b0;
    logic [8:0] hist1 = '0;
    logic [8:0] hist2 = '0;
    logic [8:0] cur_word;
    logic [8:0] rise_word = '0;

    always @(negedge clk) begin
        cur_word = {lcd_rs, lcd_data};
        if (lcd_e && !e_prev) begin
            rise_q.push_back(cyc);
            word_q.push_back(cur_word);
            rise_word = cur_word;
            if (hist1 != cur_word || hist2 != cur_word) stable_bad++;
        end else if (lcd_e && cur_word != rise_word) begin
            stable_bad++;
        end
        if (!lcd_e && e_prev) begin
            fall_q.push_back(cyc);
            if (cur_word != rise_word && !rst) stable_bad++;
        end
        e_prev = lcd_e;
        hist2  = hist1;
        hist1  = cur_word;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    int rb;

    initial begin
        rst        = 1'b1;
        force_rdy  = 1'b0;
        char_valid = 1'b0;
        char_data  = 9'h000;
        repeat (3) @(negedge clk);

        check("rst_rom_addr",   32'(rom_addr),   32'd0);
        check("rst_lcd_data",   32'(lcd_data),   32'h00);
        check("rst_lcd_rs",     32'(lcd_rs),     32'd0);
        check("rst_lcd_rw",     32'(lcd_rw),     32'd0);
        check("rst_lcd_e",      32'(lcd_e),      32'd0);
        check("rst_char_ready", 32'(char_ready), 32'd0);
        check("rst_init_done",  32'(init_done),  32'd0);
        rst = 1'b0;

        // rom_rdy forced high during power-up must be ignored.
        goto(2);
        force_rdy = 1'b1;
        goto(6);
        force_rdy = 1'b0;
        check("pwr_rdy_ignored_done", 32'(init_done), 32'd0);
        check("pwr_lcd_e",            32'(lcd_e),     32'd0);

        goto(12);
        check("boot0_setup_e",    32'(lcd_e),            32'd0);
        check("boot0_setup_word", 32'({lcd_rs, lcd_data}), 32'h03C);
        goto(13);
        check("boot0_e_rise",     32'(lcd_e),            32'd1);
        goto(16);
        check("boot0_e_fall",     32'(lcd_e),            32'd0);

        goto(69);
        check("boot_done_early",  32'(init_done),  32'd0);
        check("boot_ready_early", 32'(char_ready), 32'd0);
        goto(70);
        check("boot_done",        32'(init_done),  32'd1);
        check("boot_ready",       32'(char_ready), 32'd1);
        check("boot_rom_addr",    32'(rom_addr),   32'd4);
        check("boot_lcd_rw",      32'(lcd_rw),     32'd0);

        check("boot_pulse_count", 32'(rise_q.size()), 32'd4);
        check("boot_word0", 32'(word_q[0]), 32'h03C);
        check("boot_word1", 32'(word_q[1]), 32'h006);
        check("boot_word2", 32'(word_q[2]), 32'h001);
        check("boot_word3", 32'(word_q[3]), 32'h00F);
        check("boot_rise0", 32'(rise_q[0]), 32'd13);
        check("boot_rise3", 32'(rise_q[3]), 32'd61);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("boot_width%0d", i), 32'(fall_q[i] - rise_q[i]), 32'(E_PULSE_CYCLES));
        end
        check("gap_after_3c", 32'(rise_q[1] - fall_q[0]), 32'(GAP_CMD));
        check("gap_after_06", 32'(rise_q[2] - fall_q[1]), 32'(GAP_CMD));
        check("gap_after_01", 32'(rise_q[3] - fall_q[2]), 32'(GAP_CLR));

        // Idle stall: outputs static, no new pulses.
        goto(80);
        check("stall_lcd_e",  32'(lcd_e),                32'd0);
        check("stall_word",   32'({lcd_rs, lcd_data}),   32'h00F);
        check("stall_pulses", 32'(rise_q.size()),        32'd4);

        // Single user character 'A'.
        char_valid = 1'b1;
        char_data  = 9'h141;
        goto(81);
        char_valid = 1'b0;
        check("char_a_ready_low", 32'(char_ready),         32'd0);
        check("char_a_word",      32'({lcd_rs, lcd_data}), 32'h141);
        goto(90);
        check("char_a_ready_90",  32'(char_ready),         32'd0);
        goto(91);
        check("char_a_ready_91",  32'(char_ready),         32'd1);
        check("char_a_pulses",    32'(rise_q.size()),      32'd5);
        check("char_a_rise",      32'(rise_q[4]),          32'd83);
        check("char_a_width",     32'(fall_q[4] - rise_q[4]), 32'(E_PULSE_CYCLES));
        check("char_a_pword",     32'(word_q[4]),          32'h141);

        // Back-to-back with char_valid held; data changed while busy.
        char_valid = 1'b1;
        char_data  = 9'h148;
        goto(92);
        char_data = 9'h155;
        check("b2b_first_word",  32'({lcd_rs, lcd_data}), 32'h148);
        goto(95);
        check("b2b_busy_hold",   32'({lcd_rs, lcd_data}), 32'h148);
        goto(97);
        char_data = 9'h149;
        goto(101);
        check("b2b_ready_101",   32'(char_ready),         32'd0);
        goto(102);
        check("b2b_ready_102",   32'(char_ready),         32'd1);
        check("b2b_hold_102",    32'({lcd_rs, lcd_data}), 32'h148);
        goto(103);
        char_valid = 1'b0;
        check("b2b_second_acc",  32'(char_ready),         32'd0);
        check("b2b_second_word", 32'({lcd_rs, lcd_data}), 32'h149);
        goto(113);
        check("b2b_ready_back",  32'(char_ready),         32'd1);
        goto(120);
        check("b2b_pulse_count", 32'(rise_q.size()),      32'd7);
        check("b2b_word5",       32'(word_q[5]),          32'h148);
        check("b2b_word6",       32'(word_q[6]),          32'h149);
        check("b2b_rise6",       32'(rise_q[6]),          32'd105);

        // User clear command gets the long wait.
        char_valid = 1'b1;
        char_data  = 9'h001;
        goto(121);
        char_valid = 1'b0;
        goto(145);
        check("uclr_ready_145", 32'(char_ready), 32'd0);
        check("uclr_e_145",     32'(lcd_e),      32'd0);
        goto(146);
        check("uclr_ready_146", 32'(char_ready), 32'd1);
        check("uclr_rom_addr",  32'(rom_addr),   32'd4);
        check("uclr_width",     32'(fall_q[7] - rise_q[7]), 32'(E_PULSE_CYCLES));
        check("stable_errors",  32'(stable_bad), 32'd0);

        // Reset after init, then reset again during the third boot pulse.
        rst = 1'b1;
        @(negedge clk);
        check("rst2_init_done",  32'(init_done),  32'd0);
        check("rst2_char_ready", 32'(char_ready), 32'd0);
        check("rst2_rom_addr",   32'(rom_addr),   32'd0);
        rst = 1'b0;
        goto(36);
        check("mid_pulse_e",     32'(lcd_e),      32'd1);
        check("mid_pulse_addr",  32'(rom_addr),   32'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rst3_lcd_e",      32'(lcd_e),      32'd0);
        check("rst3_rom_addr",   32'(rom_addr),   32'd0);
        check("rst3_init_done",  32'(init_done),  32'd0);
        rst = 1'b0;
        rb = rise_q.size();
        goto(70);
        check("replay_done",     32'(init_done),          32'd1);
        check("replay_rom_addr", 32'(rom_addr),           32'd4);
        check("replay_pulses",   32'(rise_q.size() - rb), 32'd4);
        check("replay_word0",    32'(word_q[rb]),         32'h03C);
        check("replay_word1",    32'(word_q[rb + 1]),     32'h006);
        check("replay_word2",    32'(word_q[rb + 2]),     32'h001);
        check("replay_word3",    32'(word_q[rb + 3]),     32'h00F);
        check("replay_rise3",    32'(rise_q[rb + 3]),     32'd61);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_init_ctrl.md
Name: lcd_init_ctrl

Overview:
- Sequencer that sits directly in front of the 4-entry LCD boot-command ROM.
- Drives the ROM address, fetches each 9-bit word (bit 8 = RS, bits 7:0 = data), and writes it to an HD44780-style 8-bit parallel LCD with correct E-strobe and busy-wait timing.
- After the ROM reports ready, it accepts user character/command writes over a valid/ready handshake.

Parameters:
- POWERUP_WAIT, 750000: clk cycles to wait after reset before the first command (15 ms at 50 MHz).
- SETUP_CYCLES, 4: cycles RS/data are stable with E low before the E pulse.
- E_PULSE_CYCLES, 25: cycles E is held high.
- CMD_WAIT, 2000: cycles with E low after a normal command or character.
- CLEAR_WAIT, 82000: cycles with E low after a clear/home command.
- Constraint: all parameters are at least 1. The counter width is $clog2 of the largest parameter plus 1.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rom_addr  out  3  address to the boot-command ROM
- rom_q  in  9  ROM word (combinational response to rom_addr)
- rom_rdy  in  1  ROM end-of-table flag, high when rom_addr = 4
- char_valid  in  1  user write request
- char_data  in  9  user word; bit 8 = RS, 7:0 = data
- char_ready  out  1  block can accept a user word this cycle
- lcd_data  out  8  LCD DB7..DB0
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD R/W, tied 0 (write only)
- lcd_e  out  1  LCD enable strobe
- init_done  out  1  boot sequence complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high on rst. All outputs are registered.
- Reset values:
  - rom_addr = 0, lcd_data = 0x00, lcd_rs = 0, lcd_rw = 0, lcd_e = 0.
  - char_ready = 0, init_done = 0.
  - State = POWERUP, counter = 0.
- POWERUP: count POWERUP_WAIT cycles, then go to FETCH.
- FETCH (1 cycle):
  - If rom_rdy = 1: go to IDLE. init_done and char_ready rise on the next edge.
  - Otherwise: latch rom_q[8] into lcd_rs and rom_q[7:0] into lcd_data, then go to SETUP.
- SETUP: lcd_e = 0 for SETUP_CYCLES cycles, then go to PULSE.
- PULSE: lcd_e = 1 for exactly E_PULSE_CYCLES cycles, then go to WAIT.
- WAIT:
  - lcd_e = 0 for CLEAR_WAIT cycles if the latched word has rs = 0 and data[7:1] = 0 (0x01 clear, 0x02/0x03 home). Otherwise wait CMD_WAIT cycles.
  - On exit during boot: rom_addr increments by 1, then go to FETCH.
  - On exit after a user write: go to IDLE.
- Hold rule: lcd_rs and lcd_data hold the latched value from the latch edge until the next latch. They never change during SETUP, PULSE or WAIT.
- Boot order: ROM words at addresses 0,1,2,3 are issued in order.
  - rom_addr stops at 4 and is never incremented past 4.
  - With the standard ROM, the address-2 word (0x01) uses CLEAR_WAIT.
- IDLE: char_ready = 1.
  - When char_valid and char_ready are both high on an edge: latch char_data, drop char_ready, go to SETUP.
  - The word then uses the same SETUP/PULSE/WAIT path, including the clear/home wait rule.
  - char_valid is ignored while char_ready = 0. No buffering; a word is accepted only on the handshake edge.
- Stall rule: char_valid held low in IDLE keeps all LCD outputs static and lcd_e = 0.
- init_done: once set, stays 1 until rst.
- rom_rdy high during POWERUP: ignored. rom_rdy is only sampled in FETCH.
- Reset mid-operation (any state, including PULSE): on the reset edge lcd_e = 0, the state returns to POWERUP, rom_addr = 0, init_done = 0, and the full boot sequence is repeated.
- Boot timing: per-command cycle cost = 1 + SETUP_CYCLES + E_PULSE_CYCLES + wait.

Test Plan:
- Bench parameters for all scenarios: POWERUP_WAIT=10, SETUP=2, E_PULSE=3, CMD_WAIT=5, CLEAR_WAIT=20.
- Boot sequence: release rst with the standard ROM -> exactly 4 E pulses, each 3 cycles high, in order {rs,data} = 0x03C, 0x006, 0x001, 0x00F. init_done = 1 at cycle 10+11+11+26+11+1 after reset; rom_addr ends at 4.
- Timing: measure gaps around the 0x01 command -> E low exactly 20 cycles after it, 5 cycles after the others. Data/RS stable for 2 cycles before E rises and until the next latch.
- User char: after init_done, pulse char_valid with 0x141 ('A', rs=1) -> char_ready low for 10 cycles. One 3-cycle E pulse with lcd_rs = 1, lcd_data = 0x41. char_ready returns to 1.
- Back-to-back plus ignored requests:
  - Hold char_valid high with 0x148 then 0x149 -> the second word is accepted only when char_ready is high again. Exactly two pulses.
  - Changing char_data while char_ready = 0 does not alter lcd_data.
  - User word 0x001 -> 20-cycle wait.
- Reset mid-PULSE: assert rst during the third E pulse -> lcd_e = 0 on the next edge, rom_addr = 0, init_done = 0. The full 4-command boot then replays correctly.
